// File: rtl/counter_sweep_ctrl_if.sv
// rtl/counter_sweep_ctrl_if.sv - command handshake bundle for the triangle sweep sequencer
interface counter_sweep_ctrl_if #(
  parameter int WIDTH   = 6,
  parameter int REPS_W  = 4,
  parameter int DWELL_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_lo;
  logic [WIDTH-1:0]   cmd_hi;
  logic [REPS_W-1:0]  cmd_reps;
  logic [DWELL_W-1:0] cmd_dwell;

  modport master (
    output cmd_valid, cmd_lo, cmd_hi, cmd_reps, cmd_dwell,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_lo, cmd_hi, cmd_reps, cmd_dwell,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - drives the up/down counter through programmed triangle sweeps
module counter_sweep_ctrl #(
  parameter int WIDTH   = 6,
  parameter int REPS_W  = 4,
  parameter int DWELL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  counter_sweep_ctrl_if.slave cmd,
  input  logic              i_abort,
  input  logic [WIDTH-1:0]  i_cnt_value,
  output logic              o_cnt_load,
  output logic [WIDTH-1:0]  o_cnt_data,
  output logic              o_cnt_up,
  output logic              o_busy,
  output logic [REPS_W-1:0] o_reps_left,
  output logic              o_done,
  output logic              o_aborted,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UP, S_DWELL_HI, S_DOWN, S_DWELL_LO, S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [REPS_W-1:0]  r_reps_left;
  logic               r_aborted;
  logic               r_err;
  logic               w_accept;
  logic               w_reject;
  logic               w_rep_dec;
  logic               w_abort_go;
  logic               w_active;
  logic               w_dwell_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The counter has no enable, so every non-stepping cycle reloads its own value.
  always_comb begin
    w_state_nxt = r_state;
    o_cnt_load  = 1'b1;
    o_cnt_data  = i_cnt_value;
    o_cnt_up    = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_rep_dec   = 1'b0;
    w_abort_go  = 1'b0;
    w_active    = (r_state == S_LOAD) || (r_state == S_UP) || (r_state == S_DOWN) ||
                  (r_state == S_DWELL_HI) || (r_state == S_DWELL_LO);
    case (r_state)
      S_IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          if ((cmd.cmd_lo > cmd.cmd_hi) || (cmd.cmd_reps == '0)) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        o_cnt_data  = r_lo;
        w_state_nxt = S_UP;
      end
      S_UP: begin
        if (i_cnt_value != r_hi) begin
          o_cnt_load = 1'b0;
          o_cnt_up   = 1'b1;
        end else begin
          w_state_nxt = (r_dwell != '0) ? S_DWELL_HI : S_DOWN;
        end
      end
      S_DWELL_HI: begin
        if (r_dwell_cnt == '0) w_state_nxt = S_DOWN;
      end
      S_DOWN: begin
        if (i_cnt_value != r_lo) begin
          o_cnt_load = 1'b0;
        end else begin
          w_rep_dec = 1'b1;
          if (r_reps_left == REPS_W'(1)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = (r_dwell != '0) ? S_DWELL_LO : S_UP;
          end
        end
      end
      S_DWELL_LO: begin
        if (r_dwell_cnt == '0) w_state_nxt = S_UP;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides any end-point decision made above, including the rep decrement.
    if (w_active && i_abort) begin
      w_state_nxt = S_FIN;
      o_cnt_load  = 1'b1;
      o_cnt_data  = i_cnt_value;
      o_cnt_up    = 1'b0;
      w_rep_dec   = 1'b0;
      w_abort_go  = 1'b1;
    end
  end

  assign w_dwell_entry = ((w_state_nxt == S_DWELL_HI) && (r_state != S_DWELL_HI)) ||
                         ((w_state_nxt == S_DWELL_LO) && (r_state != S_DWELL_LO));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lo        <= '0;
      r_hi        <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_reps_left <= '0;
      r_aborted   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_lo        <= cmd.cmd_lo;
        r_hi        <= cmd.cmd_hi;
        r_dwell     <= cmd.cmd_dwell;
        r_reps_left <= cmd.cmd_reps;
        r_aborted   <= 1'b0;
      end
      if (w_rep_dec) r_reps_left <= r_reps_left - REPS_W'(1);
      if (w_abort_go) r_aborted <= 1'b1;
      // Dwell state lasts r_dwell cycles: load r_dwell-1 on entry, leave when it reaches 0.
      if (w_dwell_entry) begin
        r_dwell_cnt <= r_dwell - DWELL_W'(1);
      end else if (r_dwell_cnt != '0) begin
        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
      end
    end
  end

  assign cmd.cmd_ready = (r_state == S_IDLE) && i_rst_n;
  assign o_busy        = (r_state != S_IDLE);
  assign o_reps_left   = r_reps_left;
  assign o_done        = (r_state == S_FIN);
  assign o_aborted     = (r_state == S_FIN) && r_aborted;
  assign o_err         = r_err;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - scoreboard bench for counter_sweep_ctrl with a behavioural counter
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       cnt_load;
  logic [5:0] cnt_data;
  logic       cnt_up;
  logic [5:0] cnt_value = 6'd0;
  logic       busy;
  logic [3:0] reps_left;
  logic       done;
  logic       aborted;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] last_cnt = 6'd0;

  typedef struct {
    logic [6:0] flg;
    logic       chk_cnt;
    logic [5:0] cnt;
    logic       chk_reps;
    logic [3:0] reps;
  } exp_t;

  exp_t exp_q[$];

  counter_sweep_ctrl_if #(.WIDTH(6), .REPS_W(4), .DWELL_W(4)) cmd_if();

  counter_sweep_ctrl #(.WIDTH(6), .REPS_W(4), .DWELL_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .cmd         (cmd_if),
    .i_abort     (abort),
    .i_cnt_value (cnt_value),
    .o_cnt_load  (cnt_load),
    .o_cnt_data  (cnt_data),
    .o_cnt_up    (cnt_up),
    .o_busy      (busy),
    .o_reps_left (reps_left),
    .o_done      (done),
    .o_aborted   (aborted),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cnt_value <= cnt_load ? cnt_data : (cnt_up ? cnt_value + 6'd1 : cnt_value - 6'd1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // flags = {busy, done, aborted, err, ready, load, up}
  task automatic push_e(input logic [6:0] f, input logic cc, input logic [5:0] c,
                        input logic cr, input logic [3:0] r);
    exp_t e;
    e.flg = f; e.chk_cnt = cc; e.cnt = c; e.chk_reps = cr; e.reps = r;
    exp_q.push_back(e);
  endtask

  task automatic gen_sweep(input int lo, input int hi, input int reps, input int dwell);
    logic ld;
    push_e(7'b0000110, 1'b0, 6'd0, 1'b0, 4'd0);
    push_e(7'b1000010, 1'b0, 6'd0, 1'b1, 4'(reps));
    for (int r = reps; r >= 1; r--) begin
      for (int v = lo; v <= hi; v++) begin
        ld = (v == hi);
        push_e({5'b10000, ld, ~ld}, 1'b1, 6'(v), 1'b1, 4'(r));
      end
      for (int d = 0; d < dwell; d++) push_e(7'b1000010, 1'b1, 6'(hi), 1'b1, 4'(r));
      for (int v = hi; v >= lo; v--) begin
        ld = (v == lo);
        push_e({5'b10000, ld, 1'b0}, 1'b1, 6'(v), 1'b1, 4'(r));
      end
      if (r > 1) begin
        for (int d = 0; d < dwell; d++) push_e(7'b1000010, 1'b1, 6'(lo), 1'b1, 4'(r - 1));
      end
    end
    push_e(7'b1100010, 1'b1, 6'(lo), 1'b1, 4'd0);
    push_e(7'b0000110, 1'b1, 6'(lo), 1'b1, 4'd0);
    last_cnt = 6'(lo);
  endtask

  task automatic gen_err();
    push_e(7'b0000110, 1'b0, 6'd0, 1'b0, 4'd0);
    push_e(7'b0001110, 1'b1, last_cnt, 1'b1, 4'd0);
    push_e(7'b0000110, 1'b1, last_cnt, 1'b1, 4'd0);
  endtask

  // Abort trace for LO=1, HI=10, REPS=2: the abort lands in the cycle showing 4.
  task automatic gen_abort();
    push_e(7'b0000110, 1'b0, 6'd0, 1'b0, 4'd0);
    push_e(7'b1000010, 1'b0, 6'd0, 1'b1, 4'd2);
    for (int v = 1; v <= 3; v++) push_e(7'b1000001, 1'b1, 6'(v), 1'b1, 4'd2);
    push_e(7'b1000010, 1'b1, 6'd4, 1'b1, 4'd2);
    push_e(7'b1110010, 1'b1, 6'd4, 1'b1, 4'd2);
    push_e(7'b0000110, 1'b1, 6'd4, 1'b1, 4'd2);
    last_cnt = 6'd4;
  endtask

  task automatic drive_cmd(input int kind, input int lo, input int hi, input int reps, input int dwell);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_lo    = 6'(lo);
    cmd_if.cmd_hi    = 6'(hi);
    cmd_if.cmd_reps  = 4'(reps);
    cmd_if.cmd_dwell = 4'(dwell);
    case (kind)
      0: gen_sweep(lo, hi, reps, dwell);
      1: gen_err();
      2: gen_abort();
      default: ;
    endcase
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 3000 && !empty; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) empty = 1'b1;
    end
    if (!empty) begin
      check_eq("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("flags", {busy, done, aborted, err, cmd_if.cmd_ready, cnt_load, cnt_up}, e.flg);
      if (e.chk_cnt) check_eq("cnt_value", cnt_value, e.cnt);
      if (e.chk_reps) check_eq("reps_left", reps_left, e.reps);
    end
  end

  initial begin
    logic [5:0] held;
    bit found;
    rst_n = 1'b0;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_lo    = '0;
    cmd_if.cmd_hi    = '0;
    cmd_if.cmd_reps  = '0;
    cmd_if.cmd_dwell = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_flags", {busy, done, aborted, err, cmd_if.cmd_ready, cnt_load, cnt_up}, 7'b0000010);
    check_eq("rst_reps", reps_left, 4'd0);
    check_eq("rst_hold_data", cnt_data, cnt_value);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready", cmd_if.cmd_ready, 1'b1);

    drive_cmd(0, 2, 5, 1, 0);  drain();
    drive_cmd(0, 0, 63, 2, 3); drain();
    drive_cmd(1, 10, 4, 1, 0); drain();
    drive_cmd(1, 3, 9, 0, 2);  drain();
    drive_cmd(0, 7, 7, 3, 1);  drain();

    drive_cmd(0, 0, 20, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (busy && !cnt_load && !cnt_up) found = 1'b1;
    end
    check_eq("reach_down", found, 1'b1);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_flags", {busy, done, aborted, err, cmd_if.cmd_ready, cnt_load, cnt_up}, 7'b0000010);
    check_eq("mid_rst_data", cnt_data, cnt_value);
    held = cnt_value;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_frozen", cnt_value, held);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_eq("post_rst_flags", {busy, done, aborted, err, cmd_if.cmd_ready, cnt_load, cnt_up}, 7'b0000110);
    check_eq("post_rst_reps", reps_left, 4'd0);
    last_cnt = held;

    drive_cmd(2, 1, 10, 2, 0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (busy && cnt_value == 6'd3) found = 1'b1;
    end
    check_eq("reach_three", found, 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();

    drive_cmd(0, 2, 5, 1, 0); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
